stack_seq: RTL and testbench

STACK_SEQ -- requirements
Module: stack_seq

---
 rtl/stack_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_stack_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_seq.sv
// stack_seq: Moore control sequencer for 16-bit stack-pointer operations.
// It handles PUSH, POP, ADD_SP_REL and (optionally) LD_SP_IMM.
// Every control output decodes from the state register alone.
// Optional feature macro: STACK_SEQ_LDSP_EN.
//   Defined:   LD_SP_IMM loads SP from two immediate bytes (states LD1/LD2).
//   Undefined: LD_SP_IMM completes in one NOP1 cycle and leaves SP unchanged.
module stack_seq (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic [2:0] sp_sel,
  output logic [1:0] temp_buf_sel,
  output logic       write_temp_buf,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       pc_incr,
  output logic       rf_byte_sel,
  output logic       rf_write,
  output logic       done
);

  typedef enum logic [1:0] {
    OP_PUSH       = 2'd0,
    OP_POP        = 2'd1,
    OP_ADD_SP_REL = 2'd2,
    OP_LD_SP_IMM  = 2'd3
  } op_e;

  // SP next-value source codes seen by the datapath mux.
  typedef enum logic [2:0] {
    SP_HOLD = 3'd0,
    SP_INCR = 3'd1,
    SP_DECR = 3'd2,
    SP_TEMP = 3'd3,
    SP_REL  = 3'd4
  } sp_src_e;

  localparam logic [1:0] TB_DATA_BUS = 2'd0;
  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_SP     = 1'b1;
  localparam logic       BYTE_LO     = 1'b0;
  localparam logic       BYTE_HI     = 1'b1;

  // Encodings are fixed so that both builds share the same values.
  // Codes that belong to neither build fall back to IDLE.
`ifdef STACK_SEQ_LDSP_EN
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_PU1  = 4'd1,
    S_PU2  = 4'd2,
    S_PU3  = 4'd3,
    S_PO1  = 4'd4,
    S_PO2  = 4'd5,
    S_AR1  = 4'd6,
    S_LD1  = 4'd7,
    S_LD2  = 4'd8
  } state_e;
`else
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_PU1  = 4'd1,
    S_PU2  = 4'd2,
    S_PU3  = 4'd3,
    S_PO1  = 4'd4,
    S_PO2  = 4'd5,
    S_AR1  = 4'd6,
    S_NOP1 = 4'd9
  } state_e;
`endif

  // All Moore outputs as one bundle, so a single '0 gives the idle vector.
  typedef struct packed {
    logic       cmd_ready;
    sp_src_e    sp_sel;
    logic [1:0] temp_buf_sel;
    logic       write_temp_buf;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_incr;
    logic       rf_byte_sel;
    logic       rf_write;
    logic       done;
  } ctrl_t;

  state_e state;
  state_e state_nxt;
  ctrl_t  ctrl;
  op_e    op;

  assign op = op_e'(cmd_op);

  // State register. Reset forces IDLE at once, even in the middle of a command.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignment makes every flop sample pre-edge values, so there is no race between processes.
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the output decode for the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_IDLE: begin
        ctrl.cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op)
            OP_PUSH:       state_nxt = S_PU1;
            OP_POP:        state_nxt = S_PO1;
            OP_ADD_SP_REL: state_nxt = S_AR1;
`ifdef STACK_SEQ_LDSP_EN
            OP_LD_SP_IMM:  state_nxt = S_LD1;
`else
            OP_LD_SP_IMM:  state_nxt = S_NOP1;
`endif
            default:       state_nxt = S_IDLE;
          endcase
        end
      end

      // PUSH: pre-decrement, write the high byte and decrement, then write the low byte.
      S_PU1: begin
        ctrl.sp_sel = SP_DECR;
        state_nxt   = S_PU2;
      end
      S_PU2: begin
        ctrl.addr_sel    = ADDR_SP;
        ctrl.mem_wr      = 1'b1;
        ctrl.rf_byte_sel = BYTE_HI;
        ctrl.sp_sel      = SP_DECR;
        state_nxt        = S_PU3;
      end
      S_PU3: begin
        ctrl.addr_sel    = ADDR_SP;
        ctrl.mem_wr      = 1'b1;
        ctrl.rf_byte_sel = BYTE_LO;
        ctrl.done        = 1'b1;
        state_nxt        = S_IDLE;
      end

      // POP: read the low byte, then the high byte, post-incrementing SP each time.
      S_PO1: begin
        ctrl.addr_sel    = ADDR_SP;
        ctrl.mem_rd      = 1'b1;
        ctrl.rf_write    = 1'b1;
        ctrl.rf_byte_sel = BYTE_LO;
        ctrl.sp_sel      = SP_INCR;
        state_nxt        = S_PO2;
      end
      S_PO2: begin
        ctrl.addr_sel    = ADDR_SP;
        ctrl.mem_rd      = 1'b1;
        ctrl.rf_write    = 1'b1;
        ctrl.rf_byte_sel = BYTE_HI;
        ctrl.sp_sel      = SP_INCR;
        ctrl.done        = 1'b1;
        state_nxt        = S_IDLE;
      end

      // ADD_SP_REL: fetch a signed offset at PC; SP takes SP+offset on the same edge.
      S_AR1: begin
        ctrl.addr_sel = ADDR_PC;
        ctrl.mem_rd   = 1'b1;
        ctrl.pc_incr  = 1'b1;
        ctrl.sp_sel   = SP_REL;
        ctrl.done     = 1'b1;
        state_nxt     = S_IDLE;
      end

`ifdef STACK_SEQ_LDSP_EN
      // LD_SP_IMM: the low immediate goes to the temp buffer; the high immediate
      // joins it on the bus to form the new SP.
      S_LD1: begin
        ctrl.addr_sel       = ADDR_PC;
        ctrl.mem_rd         = 1'b1;
        ctrl.pc_incr        = 1'b1;
        ctrl.temp_buf_sel   = TB_DATA_BUS;
        ctrl.write_temp_buf = 1'b1;
        state_nxt           = S_LD2;
      end
      S_LD2: begin
        ctrl.addr_sel     = ADDR_PC;
        ctrl.mem_rd       = 1'b1;
        ctrl.pc_incr      = 1'b1;
        ctrl.temp_buf_sel = TB_DATA_BUS;
        ctrl.sp_sel       = SP_TEMP;
        ctrl.done         = 1'b1;
        state_nxt         = S_IDLE;
      end
`else
      // With the feature compiled out, LD_SP_IMM only completes the handshake.
      S_NOP1: begin
        ctrl.done = 1'b1;
        state_nxt = S_IDLE;
      end
`endif

      // Unused encodings: idle outputs, then back to IDLE on the next edge.
      default: begin
        ctrl      = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready      = ctrl.cmd_ready;
  assign sp_sel         = ctrl.sp_sel;
  assign temp_buf_sel   = ctrl.temp_buf_sel;
  assign write_temp_buf = ctrl.write_temp_buf;
  assign addr_sel       = ctrl.addr_sel;
  assign mem_rd         = ctrl.mem_rd;
  assign mem_wr         = ctrl.mem_wr;
  assign pc_incr        = ctrl.pc_incr;
  assign rf_byte_sel    = ctrl.rf_byte_sel;
  assign rf_write       = ctrl.rf_write;
  assign done           = ctrl.done;

  // The memory port is shared, so a read and a write can never overlap.
  a_rd_wr_exclusive : assert property (@(posedge clock) disable iff (!reset) !(mem_rd && mem_wr));

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq: randomized self-checking bench for stack_seq.
// A small behavioural environment (SP, PC, temp buffer, register pair and
// 64 KiB memory) obeys the sequencer's controls. A command-level reference
// model predicts what each command should do to that environment.
// STACK_SEQ_LDSP_EN selects which LD_SP_IMM behaviour is expected.
module tb_stack_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic [2:0] sp_sel;
  logic [1:0] temp_buf_sel;
  logic       write_temp_buf;
  logic       addr_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       pc_incr;
  logic       rf_byte_sel;
  logic       rf_write;
  logic       done;

  always #5 clock = ~clock;

  stack_seq dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_ready      (cmd_ready),
    .sp_sel         (sp_sel),
    .temp_buf_sel   (temp_buf_sel),
    .write_temp_buf (write_temp_buf),
    .addr_sel       (addr_sel),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .pc_incr        (pc_incr),
    .rf_byte_sel    (rf_byte_sel),
    .rf_write       (rf_write),
    .done           (done)
  );

  typedef struct packed {
    logic       cmd_ready;
    logic [2:0] sp_sel;
    logic [1:0] temp_buf_sel;
    logic       write_temp_buf;
    logic       addr_sel;
    logic       mem_rd;
    logic       mem_wr;
    logic       pc_incr;
    logic       rf_byte_sel;
    logic       rf_write;
    logic       done;
  } outv_t;

  outv_t obs_v;
  assign obs_v = {cmd_ready, sp_sel, temp_buf_sel, write_temp_buf, addr_sel,
                  mem_rd, mem_wr, pc_incr, rf_byte_sel, rf_write, done};

  // ---------------- behavioural environment ----------------
  logic [7:0]  mem [0:65535];
  logic [15:0] dp_sp, dp_pc;
  logic [7:0]  temp_buf, rf_hi, rf_lo;
  bit          env_init;

  bit          set_en, poke_en;
  logic [15:0] set_sp, set_pc, poke_addr;
  logic [7:0]  set_hi, set_lo, poke_data;

  logic [15:0] addr;
  logic [7:0]  data_bus;
  assign addr     = addr_sel ? dp_sp : dp_pc;
  assign data_bus = mem_rd ? mem[addr] : 8'h00;

  // The environment reacts to the controls that were valid before each edge.
  always @(posedge clock) begin
    if (!env_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
      env_init <= 1'b1;
    end
    if (set_en) begin
      dp_sp <= set_sp;
      dp_pc <= set_pc;
      rf_hi <= set_hi;
      rf_lo <= set_lo;
    end else begin
      case (sp_sel)
        3'd1: dp_sp <= dp_sp + 16'd1;
        3'd2: dp_sp <= dp_sp - 16'd1;
        3'd3: dp_sp <= {data_bus, temp_buf};
        3'd4: dp_sp <= dp_sp + {{8{data_bus[7]}}, data_bus};
        default: ;
      endcase
      if (write_temp_buf) temp_buf <= (temp_buf_sel == 2'd0) ? data_bus : 8'h00;
      if (mem_wr) mem[addr] <= rf_byte_sel ? rf_hi : rf_lo;
      if (rf_write) begin
        if (rf_byte_sel) rf_hi <= data_bus;
        else             rf_lo <= data_bus;
      end
      if (pc_incr) dp_pc <= dp_pc + 16'd1;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // The output vector each command should show in cycle k after its accept (k=0 is IDLE).
  function automatic outv_t exp_out(input int op, input int k);
    outv_t v;
    v = '0;
    if (k == 0) begin
      v.cmd_ready = 1'b1;
      return v;
    end
    case (op)
      0: case (k)
           1: v.sp_sel = 3'd2;
           2: begin v.addr_sel = 1; v.mem_wr = 1; v.rf_byte_sel = 1; v.sp_sel = 3'd2; end
           3: begin v.addr_sel = 1; v.mem_wr = 1; v.done = 1; end
           default: ;
         endcase
      1: case (k)
           1: begin v.addr_sel = 1; v.mem_rd = 1; v.rf_write = 1; v.sp_sel = 3'd1; end
           2: begin v.addr_sel = 1; v.mem_rd = 1; v.rf_write = 1; v.rf_byte_sel = 1;
                    v.sp_sel = 3'd1; v.done = 1; end
           default: ;
         endcase
      2: if (k == 1) begin v.mem_rd = 1; v.pc_incr = 1; v.sp_sel = 3'd4; v.done = 1; end
      default: begin
`ifdef STACK_SEQ_LDSP_EN
        if (k == 1) begin v.mem_rd = 1; v.pc_incr = 1; v.write_temp_buf = 1; end
        if (k == 2) begin v.mem_rd = 1; v.pc_incr = 1; v.sp_sel = 3'd3; v.done = 1; end
`else
        if (k == 1) v.done = 1;
`endif
      end
    endcase
    return v;
  endfunction

  function automatic int lat(input int op);
    case (op)
      0: return 3;
      1: return 2;
      2: return 1;
`ifdef STACK_SEQ_LDSP_EN
      default: return 2;
`else
      default: return 1;
`endif
    endcase
  endfunction

  // All tasks below start and end just after a falling edge.
  task automatic env_set(input logic [15:0] sp, input logic [15:0] pc,
                         input logic [7:0] hi, input logic [7:0] lo);
    cmd_valid = 1'b0;
    set_sp = sp; set_pc = pc; set_hi = hi; set_lo = lo; set_en = 1'b1;
    @(negedge clock);
    set_en = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    cmd_valid = 1'b0;
    poke_addr = a; poke_data = d; poke_en = 1'b1;
    @(negedge clock);
    poke_en = 1'b0;
  endtask

  // Present one command, follow its output trace and end in the IDLE cycle after done.
  task automatic run_trace(input int op, input bit keep, input int next_op);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    if (keep) cmd_op = 2'(next_op);
    else begin cmd_valid = 1'b0; cmd_op = 2'($urandom); end
    for (int k = 1; k <= lat(op); k++) begin
      if (k > 1) @(negedge clock);
      check($sformatf("op%0d_cycle%0d", op, k), 32'(obs_v), 32'(exp_out(op, k)));
    end
    @(negedge clock);
    check($sformatf("op%0d_back_to_idle", op), 32'(obs_v), 32'(exp_out(op, 0)));
  endtask

  // Reference model: predict the architectural effect of a command, then run it and compare.
  task automatic do_cmd(input int op, input bit keep, input int next_op);
    logic [15:0] sp0, pc0, e_sp, e_pc;
    logic [7:0]  hi0, lo0, e_hi, e_lo, off;
    sp0 = dp_sp; pc0 = dp_pc; hi0 = rf_hi; lo0 = rf_lo;
    e_sp = sp0; e_pc = pc0; e_hi = hi0; e_lo = lo0;
    case (op)
      0: e_sp = sp0 - 16'd2;
      1: begin e_lo = mem[sp0]; e_hi = mem[sp0 + 16'd1]; e_sp = sp0 + 16'd2; end
      2: begin off = mem[pc0]; e_sp = sp0 + {{8{off[7]}}, off}; e_pc = pc0 + 16'd1; end
      default: begin
`ifdef STACK_SEQ_LDSP_EN
        e_sp = {mem[pc0 + 16'd1], mem[pc0]};
        e_pc = pc0 + 16'd2;
`endif
      end
    endcase
    run_trace(op, keep, next_op);
    check($sformatf("op%0d_sp", op), 32'(dp_sp), 32'(e_sp));
    check($sformatf("op%0d_pc", op), 32'(dp_pc), 32'(e_pc));
    check($sformatf("op%0d_rf_hi", op), 32'(rf_hi), 32'(e_hi));
    check($sformatf("op%0d_rf_lo", op), 32'(rf_lo), 32'(e_lo));
    if (op == 0) begin
      check("push_mem_hi", 32'(mem[sp0 - 16'd1]), 32'(hi0));
      check("push_mem_lo", 32'(mem[sp0 - 16'd2]), 32'(lo0));
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] keep_hi, keep_lo;
  int gap;

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
    set_en = 1'b0; poke_en = 1'b0;
    set_sp = '0; set_pc = '0; set_hi = '0; set_lo = '0; poke_addr = '0; poke_data = '0;
    #1;
    check("reset_outputs", 32'(obs_v), 32'(exp_out(0, 0)));
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // PUSH from 0xFFFE: 0x12 at 0xFFFD, 0x34 at 0xFFFC.
    env_set(16'hFFFE, 16'h0200, 8'h12, 8'h34);
    do_cmd(0, 1'b0, 0);
    check("push_ffFD", 32'(mem[16'hFFFD]), 32'h12);
    check("push_fffc", 32'(mem[16'hFFFC]), 32'h34);
    check("push_sp",   32'(dp_sp), 32'hFFFC);

    // POP the same bytes back into a cleared register pair.
    env_set(16'hFFFC, 16'h0200, 8'h00, 8'h00);
    do_cmd(1, 1'b0, 0);
    check("pop_sp", 32'(dp_sp), 32'hFFFE);
    check("pop_hi", 32'(rf_hi), 32'h12);
    check("pop_lo", 32'(rf_lo), 32'h34);

    // ADD_SP_REL with negative and positive offsets.
    poke(16'h0300, 8'hFE);
    poke(16'h0301, 8'h05);
    env_set(16'h0100, 16'h0300, 8'h00, 8'h00);
    do_cmd(2, 1'b0, 0);
    check("add_neg_sp", 32'(dp_sp), 32'h00FE);
    env_set(16'h0100, 16'h0301, 8'h00, 8'h00);
    do_cmd(2, 1'b0, 0);
    check("add_pos_sp", 32'(dp_sp), 32'h0105);

    // LD_SP_IMM with immediates 0xCD, 0xAB.
    poke(16'h0400, 8'hCD);
    poke(16'h0401, 8'hAB);
    env_set(16'h1234, 16'h0400, 8'h00, 8'h00);
    do_cmd(3, 1'b0, 0);
`ifdef STACK_SEQ_LDSP_EN
    check("ld_sp", 32'(dp_sp), 32'hABCD);
    check("ld_pc", 32'(dp_pc), 32'h0402);
`else
    check("ld_sp", 32'(dp_sp), 32'h1234);
    check("ld_pc", 32'(dp_pc), 32'h0400);
`endif

    // Reset pulse while in PU2: outputs go idle at once and the command is abandoned.
    env_set(16'h2000, 16'h0500, 8'h77, 8'h88);
    keep_hi = mem[16'h1FFF];
    keep_lo = mem[16'h1FFE];
    cmd_valid = 1'b1; cmd_op = 2'd0;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    check("rst_in_pu2", 32'(obs_v), 32'(exp_out(0, 2)));
    #2 reset = 1'b0;
    #1 check("rst_async_idle", 32'(obs_v), 32'(exp_out(0, 0)));
    @(posedge clock);
    @(negedge clock);
    check("rst_held_idle", 32'(obs_v), 32'(exp_out(0, 0)));
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("rst_after_release", 32'(obs_v), 32'(exp_out(0, 0)));
    end
    check("rst_no_write_hi", 32'(mem[16'h1FFF]), 32'(keep_hi));
    check("rst_no_write_lo", 32'(mem[16'h1FFE]), 32'(keep_lo));
    check("rst_sp_partial", 32'(dp_sp), 32'h1FFF);

    // Back-to-back PUSH then POP with cmd_valid held high throughout.
    env_set(16'h8000, 16'h0600, 8'hA5, 8'h5A);
    do_cmd(0, 1'b1, 1);
    do_cmd(1, 1'b0, 0);
    check("b2b_sp", 32'(dp_sp), 32'h8000);
    check("b2b_hi", 32'(rf_hi), 32'hA5);
    check("b2b_lo", 32'(rf_lo), 32'h5A);

    // Random command stream with idle gaps carrying a don't-care cmd_op.
    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        @(negedge clock);
        check("idle_hold", 32'(obs_v), 32'(exp_out(0, 0)));
      end
      if ($urandom_range(0, 3) == 0)
        env_set(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      do_cmd(int'($urandom_range(0, 3)), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
